seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter N, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter RESET_PAT, default 4'b1010 (N bits), pattern value after reset.
REQ-003 Parameter CW, default 8, match counter width in bits.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 en  input  1  sample enable; digit is consumed only when en=1.
REQ-007 digit  input  1  serial input bit.
REQ-008 pat_load  input  1  load request for a new pattern.
REQ-009 pat_in  input  N  pattern value, captured when pat_load=1.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 y  output  1  registered (Moore) match flag.
REQ-013 match_cnt  output  CW  saturating count of detections.
REQ-014 armed  output  1  1 when the history holds N valid bits (fill == N).

Function
REQ-015 State: pattern reg pat[N-1:0]; history hist[N-1:0], newest bit in LSB; fill counter fill (0..N); y; match_cnt.
REQ-016 Enabled cycle (en=1, pat_load=0): hist <= {hist[N-2:0], digit}; fill <= min(fill+1, N).
REQ-017 Match condition on an enabled cycle: updated fill == N and updated hist == pat.
REQ-018 y SHALL be 1 for exactly the cycle after the edge that sampled the final pattern bit; latency is one clock.
REQ-019 y SHALL be 0 after any edge without a match, including en=0 and pat_load cycles.
REQ-020 Overlap mode (overlap=1): fill stays N after a match, so a suffix of the match can start the next one.
REQ-021 Non-overlap mode (overlap=0): fill <= 0 on a match, so the next detection needs N fresh bits.
REQ-022 overlap is sampled on each enabled cycle; a change takes effect from the next match onward.
REQ-023 fill < N SHALL suppress a match regardless of hist content, so there are no false hits after reset or load, including an all-zero pattern.
REQ-024 en=0 and pat_load=0: hist, fill, pat and match_cnt hold; y <= 0.
REQ-025 pat_load=1 (priority over en): pat <= pat_in; hist <= 0; fill <= 0; y <= 0; digit is ignored that cycle.
REQ-026 match_cnt increments by 1 per match and saturates at 2^CW-1; it never wraps.
REQ-027 clr_cnt=1 with no match: match_cnt <= 0.
REQ-028 clr_cnt=1 with a simultaneous match: match_cnt <= 1.
REQ-029 pat_load does not affect match_cnt.
REQ-030 armed SHALL be a combinational decode of the registered fill.

Reset
REQ-031 rst=0 SHALL immediately, without waiting for a clock, force: pat=RESET_PAT, hist=0, fill=0, y=0, match_cnt=0, armed=0.
REQ-032 Reset asserted in mid-sequence discards partial history; after deassertion, detection requires N new enabled bits.
REQ-033 On the first rising edge after rst returns high, the block behaves as a normal enabled, load or idle cycle.

Structure
REQ-034 Shared package seq_det_pkg SHALL hold default N, CW and RESET_PAT constants, and the fill-width function clog2(N+1).
REQ-035 The counter SHALL be one sub-module, sat_counter (parameter CW; inputs inc and clr; clr+inc yields 1).
REQ-036 The block SHALL contain no combinational path from digit to y.

Verification
REQ-037 Reset defaults, overlap=1, en=1, digits 1,0,1,0,1,0 -> y high after the 4th and 6th edges only; match_cnt=2.
REQ-038 Same stream with overlap=0 -> y high after the 4th edge only; match_cnt=1.
REQ-039 pat_load with pat_in=0000, then digits 0,0,0 -> y stays 0 and armed=0; 4th 0 -> y=1; further 0s (overlap=1) -> y=1 on every edge.
REQ-040 Pattern 1010; drive 1,0,1; drop en for 3 cycles; then 0 -> y=0 during the en=0 cycles; y=1 after the final 0.
REQ-041 CW=2 with 4 overlapping matches -> match_cnt sequence 1,2,3,3; clr_cnt on the cycle of the 5th match -> match_cnt=1.
REQ-042 Drive 1,0,1, assert rst=0 between edges, release, then drive 0 -> y=0 with fill=1; outputs read 0 during reset with no clock edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised sequence detector.
// Holds default geometry, the reset pattern and the fill-width function.
package seq_det_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_CW = 8;
    localparam logic [DEF_N-1:0] DEF_RESET_PAT = 4'b1010;

    // Bits needed to hold a fill count in the range 0..n.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the count at one.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] MAX = '1;

    // Count events, stick at all-ones, clear on request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CW'(1) : '0;
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a loadable N-bit pattern, overlap control,
// registered match flag and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             N         = DEF_N,
    parameter logic [N-1:0]   RESET_PAT = N'(DEF_RESET_PAT),
    parameter int             CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          digit,
    input  logic          pat_load,
    input  logic [N-1:0]  pat_in,
    input  logic          overlap,
    input  logic          clr_cnt,
    output logic          y,
    output logic [CW-1:0] match_cnt,
    output logic          armed
);

    localparam int FW = fill_width(N);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]  pat;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic [N-1:0]  hist_nx;
    logic [FW-1:0] fill_nx;
    logic          hit;

    // Next history/fill for an enabled sample and the resulting match.
    always_comb begin
        hist_nx = {hist[N-2:0], digit};
        fill_nx = (fill == FULL) ? FULL : fill + 1'b1;
        hit     = en && !pat_load
                  && (fill_nx == FULL)
                  && (hist_nx == pat);
    end

    // Pattern, history, fill and match flag; load wins over sampling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat  <= RESET_PAT;
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else if (pat_load) begin
            pat  <= pat_in;
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else if (en) begin
            hist <= hist_nx;
            fill <= (hit && !overlap) ? '0 : fill_nx;
            y    <= hit;
        end else begin
            y    <= 1'b0;
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (clr_cnt),
        .cnt (match_cnt)
    );

    assign armed = (fill == FULL);

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param (N=4, CW=2).
// A queue-based reference model is compared against the DUT every cycle.
module tb_seq_detector_param;

    localparam int N = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int RPAT = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          digit = 1'b0;
    logic          pat_load = 1'b0;
    logic [N-1:0]  pat_in = '0;
    logic          overlap = 1'b1;
    logic          clr_cnt = 1'b0;
    logic          y;
    logic [CW-1:0] match_cnt;
    logic          armed;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(
        .N         (N),
        .RESET_PAT (4'b1010),
        .CW        (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digit     (digit),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .overlap   (overlap),
        .clr_cnt   (clr_cnt),
        .y         (y),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    // Reference model: last N sampled bits as a queue, oldest first.
    bit mq[$];
    int m_fill = 0;
    int m_pat = RPAT;
    int m_cnt = 0;
    bit m_y = 1'b0;

    function automatic int qval();
        int v = 0;
        foreach (mq[i]) v = v * 2 + int'(mq[i]);
        return v;
    endfunction

    task automatic clear_q();
        mq.delete();
        repeat (N) mq.push_back(1'b0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        bit hit;
        if (!rst) begin
            clear_q();
            m_fill = 0;
            m_pat = RPAT;
            m_cnt = 0;
            m_y = 1'b0;
        end else begin
            hit = 1'b0;
            if (pat_load) begin
                m_pat = int'(pat_in);
                clear_q();
                m_fill = 0;
            end else if (en) begin
                mq.push_back(digit);
                void'(mq.pop_front());
                m_fill = (m_fill < N) ? m_fill + 1 : N;
                hit = (m_fill == N) && (qval() == m_pat);
                if (hit && !overlap) m_fill = 0;
            end
            if (clr_cnt) m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < CMAX) m_cnt++;
            m_y = hit;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("y", int'(y), int'(m_y));
            chk("match_cnt", int'(match_cnt), m_cnt);
            chk("armed", int'(armed), int'(m_fill == N));
        end
    end

    task automatic cyc(input bit e, input bit d, input bit ld,
                       input logic [N-1:0] pin, input bit ov,
                       input bit clr);
        en = e;
        digit = d;
        pat_load = ld;
        pat_in = pin;
        overlap = ov;
        clr_cnt = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bit_in(input bit d, input bit ov);
        cyc(1'b1, d, 1'b0, '0, ov, 1'b0);
    endtask

    task automatic load(input logic [N-1:0] p, input bit ov);
        cyc(1'b0, 1'b0, 1'b1, p, ov, 1'b1);
    endtask

    initial begin
        bit stream[6];
        int ys;
        stream = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Asynchronous reset with no clock edge.
        #1 rst = 1'b0;
        #2;
        chk("reset_y", int'(y), 0);
        chk("reset_cnt", int'(match_cnt), 0);
        chk("reset_armed", int'(armed), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Overlapping 1010 on 101010.
        ys = 0;
        foreach (stream[i]) begin
            bit_in(stream[i], 1'b1);
            ys = ys | (int'(y) << i);
        end
        chk("ovl_y_vec", ys, 6'b101000);
        chk("ovl_cnt", int'(match_cnt), 2);

        // Non-overlapping on the same stream.
        load(4'b1010, 1'b0);
        chk("load_cnt_clr", int'(match_cnt), 0);
        ys = 0;
        foreach (stream[i]) begin
            bit_in(stream[i], 1'b0);
            ys = ys | (int'(y) << i);
        end
        chk("novl_y_vec", ys, 6'b001000);
        chk("novl_cnt", int'(match_cnt), 1);

        // All-zero pattern: no hits until four samples.
        load(4'b0000, 1'b1);
        repeat (3) begin
            bit_in(1'b0, 1'b1);
            chk("zero_early_y", int'(y), 0);
            chk("zero_early_armed", int'(armed), 0);
        end
        bit_in(1'b0, 1'b1);
        chk("zero_4th_y", int'(y), 1);
        chk("zero_4th_armed", int'(armed), 1);
        repeat (2) begin
            bit_in(1'b0, 1'b1);
            chk("zero_more_y", int'(y), 1);
        end

        // Enable gaps do not break a sequence.
        load(4'b1010, 1'b1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        repeat (3) begin
            cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
            chk("gap_y", int'(y), 0);
        end
        bit_in(1'b0, 1'b1);
        chk("gap_final_y", int'(y), 1);

        // Saturation at 3 and clear coinciding with a match.
        load(4'b1010, 1'b1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("sat_cnt1", int'(match_cnt), 1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("sat_cnt2", int'(match_cnt), 2);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("sat_cnt3", int'(match_cnt), 3);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("sat_cnt4", int'(match_cnt), 3);
        bit_in(1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("clr_hit_cnt", int'(match_cnt), 1);
        chk("clr_hit_y", int'(y), 1);

        // Mid-sequence asynchronous reset discards history.
        load(4'b1010, 1'b1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        #1 rst = 1'b0;
        #2;
        chk("midrst_y", int'(y), 0);
        chk("midrst_cnt", int'(match_cnt), 0);
        chk("midrst_armed", int'(armed), 0);
        #1 rst = 1'b1;
        @(negedge clk);
        bit_in(1'b0, 1'b1);
        chk("post_rst_y", int'(y), 0);
        chk("post_rst_armed", int'(armed), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit e, d, ld, clr;
            logic [N-1:0] p;
            e = ($urandom_range(99) < 75);
            d = $urandom_range(1);
            ld = ($urandom_range(99) < 3);
            clr = ($urandom_range(99) < 5);
            p = N'($urandom_range(15));
            if ($urandom_range(99) < 4) overlap = ~overlap;
            cyc(e, d, ld, p, overlap, clr);
            if ($urandom_range(999) < 5) begin
                #1 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
